// File: rtl/uart_rx_linebuf.sv
// UART receiver feeding a line-assembling FIFO: bytes are only released once their line commits.
// Optional idle-timeout commit of partial lines: define UART_LINEBUF_TIMEOUT_EN.
module uart_rx_linebuf #(
  parameter int          DataBits   = 8,
  parameter int          Depth      = 128,
  parameter int          MaxLine    = 81,
  parameter logic [7:0]  Terminator = 8'h0A,
  parameter int          DivWidth   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         rx_i,
  input  logic [DivWidth-1:0]          div_i,
  input  logic [1:0]                   parity_i,
  output logic                         char_valid_o,
  input  logic                         char_ready_i,
  output logic [7:0]                   char_o,
  output logic                         char_last_o,
  output logic [$clog2(Depth+1)-1:0]   lines_o,
  output logic                         parity_err_o,
  output logic                         frame_err_o,
  output logic                         overflow_o
);
  localparam int AW = $clog2(Depth);
  localparam int LW = $clog2(Depth+1);
  localparam int UW = $clog2(MaxLine+1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;
  state_t state, state_n;

  logic                rx_m, rx_s, rx_d;
  logic [DivWidth-1:0] div_lat, div_cur, div_use, tcnt;
  logic                tick, half, mid, start_det;
  logic [3:0]          tidx;
  logic [2:0]          bidx;
  logic [DataBits-1:0] shreg, push_byte;
  logic [1:0]          par_lat;
  logic                par_en, par_flag, push_req;

  logic [DataBits-1:0] data_mem [Depth];
  logic [Depth-1:0]    last_mem;
  logic [AW:0]         wr_ptr, rd_ptr;
  logic [UW-1:0]       ucnt;
  logic                full, push_ok, push_last, pop, rd_last, to_fire;

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) {rx_m, rx_s, rx_d} <= 3'b111;
    else         {rx_m, rx_s, rx_d} <= {rx_i, rx_m, rx_s};

  // Idle uses the live divisor; a frame runs on the value captured at its start edge.
  assign div_cur   = (div_i == '0) ? DivWidth'(1) : div_i;
  assign div_use   = (state == IDLE) ? div_cur : div_lat;
  assign tick      = (tcnt == '0);
  assign start_det = (state == IDLE) && rx_d && !rx_s;
  assign half      = tick && (tidx == 4'd7);
  assign mid       = tick && (tidx == 4'd15);
  assign par_en    = (par_lat == 2'b01) || (par_lat == 2'b10);

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      tcnt    <= '0;
      div_lat <= DivWidth'(1);
      tidx    <= '0;
    end else if (start_det) begin
      tcnt    <= div_cur - 1'b1;
      div_lat <= div_cur;
      tidx    <= '0;
    end else begin
      tcnt <= tick ? div_use - 1'b1 : tcnt - 1'b1;
      if (tick) tidx <= (state == START && half) ? 4'd0 : tidx + 1'b1;
    end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else         state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start_det) state_n = START;
      START:   if (half) state_n = rx_s ? IDLE : DATA;
      DATA:    if (mid && bidx == 3'(DataBits-1)) state_n = par_en ? PARITY : STOP;
      PARITY:  if (mid) state_n = STOP;
      STOP:    if (mid) state_n = rx_s ? IDLE : RECOVER;
      RECOVER: if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      bidx <= '0; shreg <= '0; par_lat <= '0; par_flag <= 1'b0;
      push_req <= 1'b0; push_byte <= '0;
      frame_err_o <= 1'b0; parity_err_o <= 1'b0;
    end else begin
      push_req     <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      if (start_det) begin
        bidx     <= '0;
        par_lat  <= parity_i;
        par_flag <= 1'b0;
      end
      if (state == DATA && mid) begin
        shreg <= {rx_s, shreg[DataBits-1:1]};
        bidx  <= bidx + 1'b1;
      end
      if (state == PARITY && mid)
        par_flag <= rx_s != ((par_lat == 2'b01) ? ^shreg : ~^shreg);
      // Frame error wins over parity error; at most one pulse per frame.
      if (state == STOP && mid) begin
        if (!rx_s)         frame_err_o  <= 1'b1;
        else if (par_flag) parity_err_o <= 1'b1;
        else begin
          push_req  <= 1'b1;
          push_byte <= shreg;
        end
      end
    end

  assign full      = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign push_ok   = push_req && !full;
  assign push_last = (push_byte == Terminator[DataBits-1:0]) || (ucnt == UW'(MaxLine-1));
  assign rd_last   = last_mem[rd_ptr[AW-1:0]];
  assign pop       = char_valid_o && char_ready_i;

`ifdef UART_LINEBUF_TIMEOUT_EN
  localparam int IdleTicks = 16*20;
  logic [8:0] idle_cnt;
  assign to_fire = (state == IDLE) && (ucnt != '0) && tick && !push_req && !start_det &&
                   (idle_cnt == 9'(IdleTicks-1));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) idle_cnt <= '0;
    else if (state != IDLE || ucnt == '0 || start_det || to_fire) idle_cnt <= '0;
    else if (tick) idle_cnt <= idle_cnt + 1'b1;
`else
  assign to_fire = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      data_mem[wr_ptr[AW-1:0]] <= push_byte;
      last_mem[wr_ptr[AW-1:0]] <= push_last;
    end else if (to_fire)
      last_mem[wr_ptr[AW-1:0] - 1'b1] <= 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_ptr <= '0; rd_ptr <= '0; ucnt <= '0; lines_o <= '0; overflow_o <= 1'b0;
    end else begin
      overflow_o <= push_req && full;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        ucnt   <= push_last ? '0 : ucnt + 1'b1;
      end else if (to_fire)
        ucnt <= '0;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      lines_o <= lines_o + LW'((push_ok && push_last) || to_fire) - LW'(pop && rd_last);
    end

  // Masking keeps the outputs at zero while nothing committed is present.
  assign char_valid_o = (lines_o != '0);
  assign char_o       = char_valid_o ? 8'(data_mem[rd_ptr[AW-1:0]]) : 8'h00;
  assign char_last_o  = char_valid_o && rd_last;
endmodule

// File: tb/tb_uart_rx_linebuf.sv
// Randomised bench for uart_rx_linebuf against a queue-based line model.
module tb_uart_rx_linebuf;
  localparam int DEPTH = 8, MAXLINE = 4;
  localparam int LW = $clog2(DEPTH+1);

  logic          clk_i = 0, rst_ni = 0, rx_i = 1;
  logic [15:0]   div_i = 16'd4;
  logic [1:0]    parity_i = 2'b00;
  logic          char_ready_i = 0;
  logic          char_valid_o, char_last_o, parity_err_o, frame_err_o, overflow_o;
  logic [7:0]    char_o;
  logic [LW-1:0] lines_o;

  uart_rx_linebuf #(.DataBits(8), .Depth(DEPTH), .MaxLine(MAXLINE), .Terminator(8'h0A), .DivWidth(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .div_i(div_i), .parity_i(parity_i),
    .char_valid_o(char_valid_o), .char_ready_i(char_ready_i), .char_o(char_o),
    .char_last_o(char_last_o), .lines_o(lines_o), .parity_err_o(parity_err_o),
    .frame_err_o(frame_err_o), .overflow_o(overflow_o));

  always #5 clk_i = ~clk_i;

  typedef struct packed { logic [7:0] b; logic l; } beat_t;
  beat_t exp_q[$], pend_q[$], got_q[$], log_q[$];
  int checks = 0, passes = 0;
  int par_cnt = 0, frm_cnt = 0, ovf_cnt = 0, exp_par = 0, exp_frm = 0, exp_ovf = 0;
  bit quiet = 1;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    if (n > 0) #1;
  endtask

  initial forever begin
    @(posedge clk_i); #1;
    case (rdy_mode)
      0: char_ready_i = 1'b0;
      1: char_ready_i = 1'b1;
      default: char_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare process: pops are matched in order against committed beats; outside
  // the stop-bit window the visible state must equal the model exactly.
  initial begin
    beat_t g, e, x;
    int nl;
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        par_cnt += int'(parity_err_o);
        frm_cnt += int'(frame_err_o);
        ovf_cnt += int'(overflow_o);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
          g = got_q.pop_front();
          e = exp_q.pop_front();
          chk("pop_beat", 32'(g), 32'(e));
        end
        if (!quiet) begin
          chk("no_leak", got_q.size(), 0);
          got_q.delete();
          chk("valid", 32'(char_valid_o), 32'(exp_q.size() > 0));
          nl = 0;
          foreach (exp_q[i]) nl += int'(exp_q[i].l);
          chk("lines", 32'(lines_o), nl);
          if (exp_q.size() > 0) begin
            chk("char", 32'(char_o), 32'(exp_q[0].b));
            chk("char_last", 32'(char_last_o), 32'(exp_q[0].l));
          end
        end
        if (char_valid_o && char_ready_i) begin
          x.b = char_o; x.l = char_last_o;
          got_q.push_back(x);
          log_q.push_back(x);
        end
      end
    end
  end

  task automatic commit_pending();
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
  endtask

  task automatic model_frame(input logic [7:0] b, input bit perr, input bit ferr);
    beat_t x;
    if (ferr) exp_frm++;
    else if (perr) exp_par++;
    else if (exp_q.size() + pend_q.size() - got_q.size() >= DEPTH) exp_ovf++;
    else begin
      x.b = b;
      x.l = (b == 8'h0A) || (pend_q.size() == MAXLINE-1);
      pend_q.push_back(x);
      if (x.l) commit_pending();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic [1:0] pm, input bit perr,
                            input bit ferr, input int low_bits);
    int bt;
    logic p;
    bit pen;
    bt = 16 * ((div_i == 0) ? 1 : int'(div_i));
    pen = (pm == 2'b01) || (pm == 2'b10);
    parity_i = pm;
    rx_i = 1'b0; cyc(bt);
    for (int i = 0; i < 8; i++) begin rx_i = b[i]; cyc(bt); end
    if (pen) begin
      p = (pm == 2'b01) ? ^b : ~^b;
      rx_i = perr ? ~p : p;
      cyc(bt);
    end
    rx_i = !ferr;
    cyc(bt/4);
    quiet = 1;
    cyc(bt*7/8 - bt/4);
    model_frame(b, perr && pen, ferr);
    chk("parity_pulses", par_cnt, exp_par);
    chk("frame_pulses", frm_cnt, exp_frm);
    chk("overflow_pulses", ovf_cnt, exp_ovf);
    quiet = 0;
    cyc(bt - bt*7/8);
    if (ferr) begin
      cyc(low_bits * bt);
      rx_i = 1'b1;
      cyc(bt);
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(s[i], 2'b00, 0, 0, 0);
  endtask

  task automatic drain(input int lim);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || got_q.size() != 0) && n < lim) begin cyc(1); n++; end
    chk("drain_in_time", 32'(n < lim), 1);
    cyc(3);
  endtask

  task automatic chk_log(input int i, input logic [7:0] b, input logic l);
    if (i < log_q.size()) chk("log_beat", 32'(log_q[i]), {23'd0, b, l});
    else chk("log_len", log_q.size(), i+1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pf, ff, of, bt, occ;
    logic [7:0] b;
    cyc(5);
    chk("rst_valid", 32'(char_valid_o), 0);
    chk("rst_lines", 32'(lines_o), 0);
    chk("rst_char", {char_o, char_last_o}, 0);
    chk("rst_pulses", {parity_err_o, frame_err_o, overflow_o}, 0);
    rst_ni = 1; cyc(3); quiet = 0;

    // "Hi\n": nothing visible before the terminator.
    rdy_mode = 1; log_q.delete();
    send_str("Hi");
    chk("hold_before_term", 32'(char_valid_o), 0);
    send_str("\n");
    drain(200);
    chk("hi_len", log_q.size(), 3);
    chk_log(0, 8'h48, 0); chk_log(1, 8'h69, 0); chk_log(2, 8'h0A, 1);

    // Forced commit at MAXLINE bytes; fifth byte held.
    log_q.delete();
    send_str("ABCDE");
    drain(200);
    chk("abcde_len", log_q.size(), 4);
    chk_log(3, 8'h44, 1);
    chk("abcde_lines", 32'(lines_o), 0);
    send_str("\n");
    drain(200);

    // Even parity: 0x55 with parity bit 1 is rejected, then accepted with 0.
    log_q.delete(); pf = par_cnt;
    send_frame(8'h55, 2'b01, 1, 0, 0);
    chk("par_err_once", par_cnt - pf, 1);
    send_frame(8'h55, 2'b01, 0, 0, 0);
    send_frame(8'h0A, 2'b01, 0, 0, 0);
    drain(200);
    chk_log(0, 8'h55, 0); chk_log(1, 8'h0A, 1);

    // Frame error with a long break, then clean reception.
    log_q.delete(); ff = frm_cnt; pf = par_cnt;
    send_frame(8'h41, 2'b00, 0, 1, 30);
    send_str("A\n");
    drain(200);
    chk("frm_err_once", frm_cnt - ff, 1);
    chk("frm_no_par", par_cnt - pf, 0);
    chk_log(0, 8'h41, 0); chk_log(1, 8'h0A, 1);

    // Glitch shorter than half a bit.
    ff = frm_cnt; pf = par_cnt; of = ovf_cnt;
    rx_i = 1'b0; cyc(5*4); rx_i = 1'b1; cyc(3*64);
    chk("glitch_no_pulse", (frm_cnt - ff) + (par_cnt - pf) + (ovf_cnt - of), 0);

    // Overflow on a full FIFO with the sink stalled.
    rdy_mode = 0; cyc(2); log_q.delete(); of = ovf_cnt;
    send_str("abcdefg\n");
    send_str("z");
    chk("ovf_once", ovf_cnt - of, 1);
    chk("ovf_lines", 32'(lines_o), 2);
    chk("ovf_head", 32'(char_o), 32'h61);
    rdy_mode = 1;
    drain(200);
    chk("ovf_drained", log_q.size(), 8);
    chk_log(3, 8'h64, 1); chk_log(7, 8'h0A, 1);

    // Reset in the middle of a frame.
    rx_i = 1'b0; cyc(3*64);
    quiet = 1; rst_ni = 0; cyc(3); rx_i = 1'b1;
    exp_q.delete(); pend_q.delete(); got_q.delete();
    par_cnt = 0; frm_cnt = 0; ovf_cnt = 0; exp_par = 0; exp_frm = 0; exp_ovf = 0;
    rst_ni = 1; cyc(2);
    chk("midrst_lines", 32'(lines_o), 0);
    quiet = 0; log_q.delete();
    send_str("R\n");
    drain(200);
    chk_log(0, 8'h52, 0); chk_log(1, 8'h0A, 1);

    // Randomised frames, divisors, parity modes, errors and sink stalls.
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      occ = exp_q.size() + pend_q.size();
      if (occ >= DEPTH-1) begin rdy_mode = 1; drain(400); rdy_mode = 2; end
      div_i = 16'($urandom_range(0, 3));
      bt = 16 * ((div_i == 0) ? 1 : int'(div_i));
      b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
      send_frame(b, 2'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3));
      cyc(bt * $urandom_range(0, 2));
    end
    rdy_mode = 1; div_i = 16'd4;
    send_str("\n");
    drain(400);

    // Idle period with a partial line pending.
    log_q.delete();
    send_str("ok");
`ifdef UART_LINEBUF_TIMEOUT_EN
    quiet = 1;
    cyc(24*64);
    if (pend_q.size() > 0) pend_q[pend_q.size()-1].l = 1'b1;
    commit_pending();
    quiet = 0;
    drain(200);
    chk("timeout_len", log_q.size(), 2);
    chk_log(0, 8'h6F, 0); chk_log(1, 8'h6B, 1);
`else
    cyc(24*64);
    chk("no_timeout_valid", 32'(char_valid_o), 0);
    chk("no_timeout_lines", 32'(lines_o), 0);
    send_str("\n");
    drain(200);
    chk("late_commit_len", log_q.size(), 3);
    chk_log(1, 8'h6B, 0); chk_log(2, 8'h0A, 1);
`endif
    cyc(10);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
